// File: rtl/mem_stage_hs.sv
// rtl/mem_stage_hs.sv - MEM stage with req/gnt/rvalid memory handshake, freeze and MEM/WB register (optional MEM_STALL_CNT_EN)
module mem_stage_hs #(
    parameter int DATA_W    = 32,
    parameter int DEST_W    = 4,
    parameter int MEM_AW    = 8,
    parameter int BASE_ADDR = 1024,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WB_EN_MEM,
    input  logic              MEM_R_EN_MEM,
    input  logic              MEM_W_EN_MEM,
    input  logic [DATA_W-1:0] alu_res_MEM,
    input  logic [DATA_W-1:0] rm_val_MEM,
    input  logic [DEST_W-1:0] dest_MEM,
    output logic              freeze,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              WB_EN_WB,
    output logic              MEM_R_EN_WB,
    output logic [DATA_W-1:0] alu_res_WB,
    output logic [DATA_W-1:0] data_WB,
    output logic [DEST_W-1:0] dest_WB
`ifdef MEM_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    state_t state;

    logic is_read;
    logic is_write;
    logic memop;
    logic done;
    logic rd_done;

    // A load with the store enable also set is treated as a plain read.
    assign is_read  = MEM_R_EN_MEM;
    assign is_write = MEM_W_EN_MEM & ~MEM_R_EN_MEM;
    assign memop    = is_read | is_write;

    assign rd_done = (state == S_RESP) & mem_rvalid;
    assign done    = (is_write & mem_gnt & ((state == S_IDLE) | (state == S_REQ))) | rd_done;

    assign mem_req   = rst & (((state == S_IDLE) & memop) | (state == S_REQ));
    assign mem_we    = rst & is_write;
    assign freeze    = rst & memop & ~done;
    assign mem_wdata = rm_val_MEM;
    assign mem_addr  = MEM_AW'((alu_res_MEM - DATA_W'(BASE_ADDR)) >> 2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (memop) begin
                        if (!mem_gnt)
                            state <= S_REQ;
                        else if (is_read)
                            state <= S_RESP;
                    end
                end
                S_REQ: begin
                    if (mem_gnt)
                        state <= is_read ? S_RESP : S_IDLE;
                end
                S_RESP: begin
                    if (mem_rvalid)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Frozen cycles push a bubble into WB; data fields hold their last values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WB_EN_WB    <= 1'b0;
            MEM_R_EN_WB <= 1'b0;
            alu_res_WB  <= '0;
            data_WB     <= '0;
            dest_WB     <= '0;
        end else if (freeze) begin
            WB_EN_WB    <= 1'b0;
            MEM_R_EN_WB <= 1'b0;
        end else begin
            WB_EN_WB    <= WB_EN_MEM;
            MEM_R_EN_WB <= MEM_R_EN_MEM;
            alu_res_WB  <= alu_res_MEM;
            dest_WB     <= dest_MEM;
            if (rd_done)
                data_WB <= mem_rdata;
        end
    end

`ifdef MEM_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (freeze && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
    end
`else
    logic [CNT_W-1:0] unused_stall_cnt;
    assign unused_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_stage_hs.sv
// tb/tb_mem_stage_hs.sv - directed and randomized bench for mem_stage_hs against a transaction-level model
module tb_mem_stage_hs;

`ifdef MEM_STALL_CNT_EN
    localparam int CNT_W = 3;
`else
    localparam int CNT_W = 16;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        WB_EN_MEM = 1'b0, MEM_R_EN_MEM = 1'b0, MEM_W_EN_MEM = 1'b0;
    logic [31:0] alu_res_MEM = '0, rm_val_MEM = '0;
    logic [3:0]  dest_MEM = '0;
    logic        freeze, mem_req, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        WB_EN_WB, MEM_R_EN_WB;
    logic [31:0] alu_res_WB, data_WB;
    logic [3:0]  dest_WB;
`ifdef MEM_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Model: m_granted = a read was accepted and its data is still owed.
    logic        m_granted = 1'b0, m_busy = 1'b0;
    logic        m_wb_en = 1'b0, m_mr = 1'b0;
    logic [31:0] m_alu = '0, m_data = '0;
    logic [3:0]  m_dest = '0;
    int          m_stall = 0;

    mem_stage_hs #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst_n),
        .WB_EN_MEM(WB_EN_MEM), .MEM_R_EN_MEM(MEM_R_EN_MEM), .MEM_W_EN_MEM(MEM_W_EN_MEM),
        .alu_res_MEM(alu_res_MEM), .rm_val_MEM(rm_val_MEM), .dest_MEM(dest_MEM),
        .freeze(freeze), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .WB_EN_WB(WB_EN_WB), .MEM_R_EN_WB(MEM_R_EN_WB), .alu_res_WB(alu_res_WB),
        .data_WB(data_WB), .dest_WB(dest_WB)
`ifdef MEM_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_op(input logic wb, input logic r, input logic w,
                          input logic [31:0] alu, input logic [31:0] rm, input logic [3:0] dst);
        WB_EN_MEM = wb; MEM_R_EN_MEM = r; MEM_W_EN_MEM = w;
        alu_res_MEM = alu; rm_val_MEM = rm; dest_MEM = dst;
    endtask

    task automatic cycle(input logic g, input logic v, input logic [31:0] d);
        logic rd, wr, memop, done, e_req, e_frz;
        logic [31:0] off;
        mem_gnt = g; mem_rvalid = v; mem_rdata = d;
        #1;
        rd = MEM_R_EN_MEM;
        wr = MEM_W_EN_MEM & ~MEM_R_EN_MEM;
        memop = rd | wr;
        if (!rst_n) begin
            e_req = 1'b0; e_frz = 1'b0; done = 1'b0;
        end else begin
            e_req = memop & ~m_granted;
            done  = wr ? (g & ~m_granted) : (rd & m_granted & v);
            e_frz = memop & ~done;
        end
        off = alu_res_MEM - 32'd1024;
        check_eq("mem_req", {31'b0, mem_req}, {31'b0, e_req});
        check_eq("freeze", {31'b0, freeze}, {31'b0, e_frz});
        check_eq("mem_we", {31'b0, mem_we}, {31'b0, rst_n & wr});
        check_eq("mem_addr", {24'b0, mem_addr}, (off / 4) % 256);
        check_eq("mem_wdata", mem_wdata, rm_val_MEM);
        if (!rst_n) begin
            m_granted = 1'b0; m_busy = 1'b0; m_wb_en = 1'b0; m_mr = 1'b0;
            m_alu = '0; m_data = '0; m_dest = '0; m_stall = 0;
        end else begin
            if (rd && g && !m_granted) m_granted = 1'b1;
            else if (done) m_granted = 1'b0;
            if (!e_frz) begin
                m_wb_en = WB_EN_MEM; m_mr = MEM_R_EN_MEM;
                m_alu = alu_res_MEM; m_dest = dest_MEM;
                if (rd && done) m_data = d;
            end else begin
                m_wb_en = 1'b0; m_mr = 1'b0;
            end
            if (e_frz && m_stall < (1 << CNT_W) - 1) m_stall++;
            m_busy = e_frz;
        end
        @(posedge clk);
        #1;
        check_eq("WB_EN_WB", {31'b0, WB_EN_WB}, {31'b0, m_wb_en});
        check_eq("MEM_R_EN_WB", {31'b0, MEM_R_EN_WB}, {31'b0, m_mr});
        check_eq("alu_res_WB", alu_res_WB, m_alu);
        check_eq("data_WB", data_WB, m_data);
        check_eq("dest_WB", {28'b0, dest_WB}, {28'b0, m_dest});
`ifdef MEM_STALL_CNT_EN
        check_eq("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
    endtask

    initial begin
        int k;
        // Reset state
        rst_n = 1'b0;
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'hFFFF_FFFF);
        rst_n = 1'b1;

        // Non-memory op
        set_op(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 4'd3);
        cycle(1'b0, 1'b0, 32'h0);
        check_eq("t1_alu_res_WB", alu_res_WB, 32'h55);

        // Store granted in the request cycle
        set_op(1'b0, 1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF, 4'd0);
        mem_gnt = 1'b1;
        #1;
        check_eq("t2_mem_addr", {24'b0, mem_addr}, 32'd2);
        cycle(1'b1, 1'b0, 32'h0);

        // Load: gnt at cycle 2, rvalid at cycle 4 (early rvalid must be ignored)
        set_op(1'b1, 1'b1, 1'b0, 32'd1040, 32'h0, 4'd5);
        cycle(1'b0, 1'b1, 32'hBAD0_BAD0);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h1234_5678);
        check_eq("t3_data_WB", data_WB, 32'h1234_5678);
        check_eq("t3_MEM_R_EN_WB", {31'b0, MEM_R_EN_WB}, 32'd1);
`ifdef MEM_STALL_CNT_EN
        check_eq("t6_stall_cnt", 32'(stall_cnt), 32'd4);
`endif

        // Reset while waiting for read data; late rvalid is dropped
        set_op(1'b1, 1'b1, 1'b0, 32'd1100, 32'h0, 4'd7);
        cycle(1'b1, 1'b0, 32'h0);
        rst_n = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, 32'd1024, 32'h0, 4'd0);
        cycle(1'b0, 1'b1, 32'hAAAA_AAAA);
        rst_n = 1'b1;
        cycle(1'b0, 1'b1, 32'h5555_5555);
        check_eq("t4_data_WB", data_WB, 32'h0);

        // Both enables: read wins
        set_op(1'b1, 1'b1, 1'b1, 32'd1028, 32'h0BAD_F00D, 4'd9);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'hCAFE_F00D);
        check_eq("t5_data_WB", data_WB, 32'hCAFE_F00D);

`ifdef MEM_STALL_CNT_EN
        // Saturation with gnt held low
        set_op(1'b0, 1'b1, 1'b0, 32'd1024, 32'h0, 4'd1);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 32'h0);
        check_eq("t6_stall_sat", 32'(stall_cnt), 32'd7);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h0101_0101);
`endif

        // Randomized traffic with occasional mid-transaction resets
        for (int i = 0; i < 600; i++) begin
            if (!m_busy) begin
                k = $urandom_range(0, 3);
                set_op(1'($urandom_range(0, 1)), (k == 1 || k == 3), (k == 2 || k == 3),
                       ($urandom_range(0, 3) == 0) ? $urandom : 32'd1024 + $urandom_range(0, 2047),
                       $urandom, 4'($urandom_range(0, 15)));
            end
            rst_n = ($urandom_range(0, 59) != 0);
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        end
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
